// File: rtl/timer_array_pkg.sv
// timer_array_pkg: register map, CTRL fields, modes and channel FSM states for timer_array.
package timer_array_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam int CTRL_PEND = 4;
    localparam int CTRL_PSC  = 8;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT} state_t;
endpackage

// File: rtl/timer_array_channel.sv
// timer_array_channel: one 32-bit down-counter with CTRL/PRESET/COUNT and sticky PEND.
// TIMER_ARRAY_PRESCALER_EN adds the CTRL[15:8] tick prescaler.
module timer_array_channel
    import timer_array_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic        preset_we,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);
    state_t state, state_n;
    logic en, im, pend, tick, expire;
    logic [1:0] mode;
    logic [7:0] psc;
`ifdef TIMER_ARRAY_PRESCALER_EN
    logic [7:0] pcnt;
    assign tick = pcnt == psc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc  <= '0;
            pcnt <= '0;
        end else begin
            if (ctrl_we) psc <= wdata[CTRL_PSC+:8];
            if (state == ST_LOAD) pcnt <= '0;
            else if (state == ST_CNT && en) pcnt <= tick ? 8'd0 : pcnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
    assign psc  = 8'd0;
`endif
    always_comb begin
        state_n = state;
        expire  = 1'b0;
        case (state)
            ST_IDLE: state_n = en ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_n = ST_CNT;
            ST_CNT: begin
                expire  = en && tick && count == 32'd0;
                state_n = !en ? ST_IDLE : !expire ? ST_CNT : mode == MODE_RELOAD ? ST_LOAD : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // A CTRL write beats the one-shot EN clear, so EN=1 written at expiry restarts the channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            pend   <= 1'b0;
            preset <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            if (ctrl_we) begin
                en   <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE+:2];
                im   <= wdata[CTRL_IM];
            end else if (expire && mode != MODE_RELOAD) en <= 1'b0;
            pend <= expire | (pend & ~(ctrl_we & wdata[CTRL_PEND]));
            if (preset_we) preset <= wdata;
            if (state == ST_LOAD) count <= preset;
            else if (state == ST_CNT && en && tick && count != 32'd0) count <= count - 32'd1;
        end
    end
    assign ctrl = {16'd0, psc, 3'd0, pend, im, mode, en};
    assign irq  = pend & im;
endmodule

// File: rtl/timer_array.sv
// timer_array: CH_NUM bridge-mapped timer channels; address decode, write fan-out, read mux.
// Optional prescaler per channel under TIMER_ARRAY_PRESCALER_EN.
module timer_array
    import timer_array_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int ADDR_W = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CH_NUM-1:0]   irq
);
    localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
    localparam int DB = CH_NUM > 1 ? 2 + CW : 2;
    logic [CW-1:0] ch;
    logic [1:0] rsel;
    logic ok, unused_addr;
    logic [31:0] c_ctrl [CH_NUM];
    logic [31:0] c_preset [CH_NUM];
    logic [31:0] c_count [CH_NUM];
    if (CH_NUM > 1) begin : g_dec
        assign ch = addr[2+:CW];
    end else begin : g_one
        assign ch = '0;
    end
    assign unused_addr = ^addr[ADDR_W-1:DB];
    assign rsel = addr[1:0];
    assign ok   = int'(ch) < CH_NUM;
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        timer_array_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .ctrl_we   (we && ch == CW'(i) && rsel == REG_CTRL),
            .preset_we (we && ch == CW'(i) && rsel == REG_PRESET),
            .wdata     (wdata),
            .ctrl      (c_ctrl[i]),
            .preset    (c_preset[i]),
            .count     (c_count[i]),
            .irq       (irq[i])
        );
    end
    always_comb begin
        rdata = '0;
        if (ok)
            rdata = rsel == REG_CTRL ? c_ctrl[ch] : rsel == REG_PRESET ? c_preset[ch] :
                    rsel == REG_COUNT ? c_count[ch] : 32'd0;
    end
endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: directed and random stimulus against a cycle-level model of timer_array.
module tb_timer_array;
    localparam int N = 3;
    logic clk = 1'b0, reset = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0, rdata;
    logic [N-1:0] irq;
    int checks = 0, errors = 0;
    int m_en[N], m_mode[N], m_im[N], m_pend[N], m_psc[N], m_pcnt[N], m_ph[N];
    logic [31:0] m_pre[N], m_cnt[N];

    timer_array #(.CH_NUM(N), .ADDR_W(30)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_en[k] = 0; m_mode[k] = 0; m_im[k] = 0; m_pend[k] = 0;
            m_psc[k] = 0; m_pcnt[k] = 0; m_ph[k] = 0; m_pre[k] = 0; m_cnt[k] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [29:0] a);
        int c, r;
        c = int'(a[3:2]);
        r = int'(a[1:0]);
        if (c >= N) return 0;
        case (r)
            0: return (m_psc[c] << 8) | (m_pend[c] << 4) | (m_im[c] << 3) | (m_mode[c] << 1) | m_en[c];
            1: return m_pre[c];
            2: return m_cnt[c];
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_irq();
        logic [31:0] v = 0;
        for (int k = 0; k < N; k++) v[k] = m_pend[k] != 0 && m_im[k] != 0;
        return v;
    endfunction

    // Phases: 0 idle, 1 load, 2 counting; all next values derive from pre-edge values.
    task automatic model_update(input logic w, input logic [29:0] a, input logic [31:0] d);
        for (int k = 0; k < N; k++) begin
            bit wr, wc, tick, exp_now;
            int nph;
            wr = w && int'(a[3:2]) == k;
            wc = wr && a[1:0] == 2'd0;
            tick = m_pcnt[k] == m_psc[k];
            exp_now = m_ph[k] == 2 && m_en[k] != 0 && tick && m_cnt[k] == 0;
            if (m_ph[k] == 0) nph = m_en[k] != 0 ? 1 : 0;
            else if (m_ph[k] == 1) nph = 2;
            else if (m_en[k] == 0) nph = 0;
            else if (exp_now) nph = m_mode[k] == 1 ? 1 : 0;
            else nph = 2;
            if (m_ph[k] == 1) begin
                m_cnt[k] = m_pre[k];
                m_pcnt[k] = 0;
            end else if (m_ph[k] == 2 && m_en[k] != 0) begin
                if (tick && m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
                m_pcnt[k] = tick ? 0 : m_pcnt[k] + 1;
            end
            m_pend[k] = (exp_now || (m_pend[k] != 0 && !(wc && d[4]))) ? 1 : 0;
            if (wc) begin
                m_en[k] = d[0];
                m_mode[k] = d[2:1];
                m_im[k] = d[3];
`ifdef TIMER_ARRAY_PRESCALER_EN
                m_psc[k] = d[15:8];
`endif
            end else if (exp_now && m_mode[k] != 1) m_en[k] = 0;
            if (wr && a[1:0] == 2'd1) m_pre[k] = d;
            m_ph[k] = nph;
        end
    endtask

    task automatic step(input logic w, input logic [29:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
        #1;
        chk("rdata", rdata, model_read(a));
        chk("irq", {29'd0, irq}, model_irq());
        @(posedge clk);
        model_update(w, a, d);
        #1;
    endtask

    task automatic wait_rise(input int b, output int n);
        n = 0;
        do begin
            step(1'b0, 30'd0, 32'd0);
            n++;
        end while (!irq[b] && n < 40);
    endtask

    initial begin
        int n, m;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {29'd0, irq}, 32'd0);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 30'(a), 32'd0);
            chk("reset_reg", rdata, 32'd0);
        end
        // ch0 one-shot, PRESET=5
        step(1'b1, 30'd1, 32'd5);
        step(1'b1, 30'd0, 32'h9);
        wait_rise(0, n);
        chk("oneshot_latency", 32'(n), 32'd8);
        step(1'b0, 30'd0, 32'd0);
        chk("oneshot_ctrl", rdata, 32'h18);
        repeat (4) step(1'b0, 30'd2, 32'd0);
        chk("oneshot_count", rdata, 32'd0);
        chk("oneshot_irq_held", 32'(irq[0]), 32'd1);
        step(1'b1, 30'd0, 32'h10);
        chk("oneshot_w1c", 32'(irq[0]), 32'd0);
        // ch1 auto-reload, PRESET=3
        step(1'b1, 30'd5, 32'd3);
        step(1'b1, 30'd4, 32'hB);
        wait_rise(1, n);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 30'd4, 32'h1B);
            wait_rise(1, n);
            chk("reload_period", 32'(n + 1), 32'd5);
            chk("reload_ch0_quiet", 32'(irq[0]), 32'd0);
        end
        step(1'b1, 30'd4, 32'h10);
        // ch2 mid-count disable
        step(1'b1, 30'd9, 32'd10);
        step(1'b1, 30'd8, 32'h1);
        n = 0;
        do begin
            step(1'b0, 30'd10, 32'd0);
            n++;
        end while (rdata != 32'd3 && n < 40);
        step(1'b1, 30'd8, 32'h0);
        repeat (6) step(1'b0, 30'd10, 32'd0);
        chk("midcount_hold", rdata, 32'd2);
        step(1'b0, 30'd8, 32'd0);
        chk("midcount_nopend", rdata, 32'd0);
        step(1'b1, 30'd8, 32'h1);
        step(1'b0, 30'd10, 32'd0);
        step(1'b0, 30'd10, 32'd0);
        chk("midcount_reload", rdata, 32'd10);
        step(1'b1, 30'd8, 32'h0);
        // ch2 W1C on the expiry edge
        step(1'b1, 30'd9, 32'd2);
        step(1'b1, 30'd8, 32'h9);
        repeat (4) step(1'b0, 30'd8, 32'd0);
        step(1'b1, 30'd8, 32'h18);
        chk("w1c_vs_set", rdata, 32'h18);
        chk("w1c_vs_set_irq", 32'(irq[2]), 32'd1);
        step(1'b1, 30'd8, 32'h10);
        // ignored writes
        step(1'b1, 30'd10, 32'hDEAD);
        chk("count_ro", rdata, 32'd0);
        step(1'b1, 30'd12, 32'h9);
        step(1'b1, 30'd13, 32'h7);
        for (int a = 12; a < 16; a++) begin
            step(1'b0, 30'(a), 32'd0);
            chk("bad_ch_read", rdata, 32'd0);
        end
        step(1'b0, 30'd1, 32'd0);
        chk("bad_ch_no_alias", rdata, 32'd5);
`ifdef TIMER_ARRAY_PRESCALER_EN
        step(1'b1, 30'd1, 32'd1);
        step(1'b1, 30'd0, 32'h20B);
        wait_rise(0, n);
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 30'd0, 32'h21B);
            wait_rise(0, n);
            chk("psc_period", 32'(n + 1), 32'd7);
        end
        step(1'b1, 30'd0, 32'h10);
`endif
        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [29:0] a;
            logic [31:0] d;
            a = 30'($urandom_range(0, 15));
            d = a[1:0] == 2'd1 ? 32'($urandom_range(0, 6)) :
                (32'($urandom) & 32'h1F) | (32'($urandom_range(0, 2)) << 8);
            step($urandom_range(0, 3) == 0, a, d);
        end
        step(1'b1, 30'd1, 32'd20);
        step(1'b1, 30'd0, 32'h1B);
        repeat (30) step(1'b0, 30'd2, 32'd0);
        m = int'(rdata);
        // asynchronous reset mid-count
        reset = 1'b0;
        #1;
        chk("async_reset_irq", {29'd0, irq}, 32'd0);
        chk("async_reset_count", rdata, 32'd0);
        chk("running_before_reset", 32'(m != 0), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int a = 0; a < 12; a++) step(1'b0, 30'(a), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
